vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator. It is the successor to the fixed 640x480 VIBGYOR colour-bar top level. The block derives a pixel tick from the system clock and runs horizontal and vertical counters with configurable porches, sync widths and polarity. It drives RGB from a selectable pattern (vertical bars, horizontal bars, checker, rotating bars) of up to 8 palette colours. It sits directly in front of the board VGA connector.

---
 rtl/vga_pattern_gen.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator. A clock divider
//   produces a pixel tick (pix_en). Horizontal and vertical counters run off
//   that tick. RGB comes from one of four patterns built from an 8-entry
//   palette.
//
//   Optional build macro: VGA_PATTERN_BORDER_EN. When it is defined, the
//   outermost ring of active pixels is forced to white in every mode.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high reset
//   mode[1:0]   pattern select, sampled at frame start:
//                 0 vertical bars, 1 horizontal bars, 2 checker,
//                 3 rotating vertical bars
//   hsync/vsync sync outputs, asserted level = SYNC_POL
//   red/grn/blu pixel colour, zero outside active video
//   active      registered pixel lies inside the visible area
//   pixel_x/y   coordinates of the pixel currently on the outputs
//   frame_start one-clock pulse with the tick that loads pixel (0,0)
module vga_pattern_gen #(
  parameter int unsigned COLOR_W       = 4,
  parameter int unsigned CNT_W         = 11,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned NUM_BARS      = 7,
  parameter int unsigned SCROLL_FRAMES = 60
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] grn,
  output logic [COLOR_W-1:0] blu,
  output logic               active,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BW      = H_ACTIVE / NUM_BARS;
  localparam int unsigned BH      = V_ACTIVE / NUM_BARS;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FR_W    = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(SCROLL_FRAMES - 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] BW_LAST  = CNT_W'(BW - 1);
  localparam logic [CNT_W-1:0] BH_LAST  = CNT_W'(BH - 1);

  localparam logic [2:0] BAR_LAST = 3'(NUM_BARS - 1);
  localparam logic [3:0] NB4      = 4'(NUM_BARS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [CNT_W-1:0] h_count, v_count;
  logic [CNT_W-1:0] h_sub, v_sub;
  logic [2:0]       hbar, vbar;
  logic [2:0]       rot;
  logic [FR_W-1:0]  frame_cnt;
  logic [1:0]       mode_q;

  // ---------------------------------------------------------------------------
  // Combinational pixel evaluation for the current counter value
  // ---------------------------------------------------------------------------
  logic             frame_first;
  logic [1:0]       cur_mode;
  logic             vis;
  logic             hs_on, vs_on;
  logic             border;
  logic [2:0]       add_a, add_b;
  logic [3:0]       sum;
  logic [2:0]       cidx;
  logic [11:0]      pal;
  logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'h80F; // violet
      3'd1:    c = 12'h408; // indigo
      3'd2:    c = 12'h00F; // blue
      3'd3:    c = 12'h0F0; // green
      3'd4:    c = 12'hFF0; // yellow
      3'd5:    c = 12'hF80; // orange
      3'd6:    c = 12'hF00; // red
      default: c = 12'hFFF; // white
    endcase
    return c;
  endfunction

  // MSB-align a 4-bit palette channel to COLOR_W: zero-pad or drop low bits.
  function automatic logic [COLOR_W-1:0] align(input logic [3:0] c);
    logic [COLOR_W+3:0] t;
    t = {c, {COLOR_W{1'b0}}};
    return t[COLOR_W+3 -: COLOR_W];
  endfunction

  assign pix_en      = (div_cnt == DIV_LAST);
  assign frame_first = (h_count == '0) && (v_count == '0);

  // The frame's first pixel already uses the newly sampled mode, so the
  // whole frame is rendered in a single mode.
  assign cur_mode = frame_first ? mode : mode_q;

  always_comb begin
    vis   = (h_count < H_ACT_C) && (v_count < V_ACT_C);
    hs_on = (h_count >= HS_START) && (h_count <= HS_END);
    vs_on = (v_count >= VS_START) && (v_count <= VS_END);
`ifdef VGA_PATTERN_BORDER_EN
    border = (h_count == '0) || (h_count == H_EDGE) ||
             (v_count == '0) || (v_count == V_EDGE);
`else
    border = 1'b0;
`endif
  end

  // Both addends are below NUM_BARS, so one conditional subtract implements
  // the modulo.
  always_comb begin
    add_a = hbar;
    add_b = '0;
    case (cur_mode)
      2'd0: begin add_a = hbar; add_b = '0;   end
      2'd1: begin add_a = vbar; add_b = '0;   end
      2'd2: begin add_a = hbar; add_b = vbar; end
      default: begin add_a = hbar; add_b = rot; end
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b};
    if (sum >= NB4) sum = sum - NB4;
    cidx  = 3'(sum);
    pal   = palette(cidx);
    pat_r = align(pal[11:8]);
    pat_g = align(pal[7:4]);
    pat_b = align(pal[3:0]);
  end

  // ---------------------------------------------------------------------------
  // Divider, timing counters, bar trackers, rotation
  // ---------------------------------------------------------------------------
  // h_sub/hbar and v_sub/vbar advance in lock-step with h_count/v_count,
  // so they always describe the pixel addressed by the counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      h_count   <= '0;
      v_count   <= '0;
      h_sub     <= '0;
      v_sub     <= '0;
      hbar      <= '0;
      vbar      <= '0;
      rot       <= '0;
      frame_cnt <= '0;
      mode_q    <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);

      if (pix_en) begin
        if (frame_first) mode_q <= mode;

        if (h_count == H_LAST) begin
          h_count <= '0;
          h_sub   <= '0;
          hbar    <= '0;
          if (v_count == V_LAST) begin
            v_count <= '0;
            v_sub   <= '0;
            vbar    <= '0;
            // End of frame: count frames for the mode-3 rotation.
            if (frame_cnt == FR_LAST) begin
              frame_cnt <= '0;
              rot       <= (rot == BAR_LAST) ? '0 : rot + 3'(1);
            end else begin
              frame_cnt <= frame_cnt + FR_W'(1);
            end
          end else begin
            v_count <= v_count + CNT_W'(1);
            if (v_sub == BH_LAST) begin
              v_sub <= '0;
              if (vbar != BAR_LAST) vbar <= vbar + 3'(1);
            end else begin
              v_sub <= v_sub + CNT_W'(1);
            end
          end
        end else begin
          h_count <= h_count + CNT_W'(1);
          if (h_sub == BW_LAST) begin
            h_sub <= '0;
            if (hbar != BAR_LAST) hbar <= hbar + 3'(1);
          end else begin
            h_sub <= h_sub + CNT_W'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: one pixel tick behind the counters, all aligned
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      red         <= '0;
      grn         <= '0;
      blu         <= '0;
      active      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_first;
      if (pix_en) begin
        hsync   <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync   <= vs_on ? SYNC_POL : ~SYNC_POL;
        active  <= vis;
        pixel_x <= h_count;
        pixel_y <= v_count;
        if (!vis) begin
          red <= '0;
          grn <= '0;
          blu <= '0;
        end else if (border) begin
          red <= '1;
          grn <= '1;
          blu <= '1;
        end else begin
          red <= pat_r;
          grn <= pat_g;
          blu <= pat_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen using a reduced raster (16x16 active,
// 20x20 total, CLK_DIV=4, 7 bars, SCROLL_FRAMES=2).
//   Bar geometry: BW=BH=2, bars 0..5 cover 0..11, bar 6 covers 12..15.
//   hsync low for x=17..18, vsync low for y=17..18.
//   Line = 80 clocks, frame = 1600 clocks.
module tb_vga_pattern_gen;

  localparam int unsigned CNT_W = 11;

`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic             hsync, vsync, active, frame_start;
  logic [3:0]       red, grn, blu;
  logic [CNT_W-1:0] pixel_x, pixel_y;

  int checks = 0;
  int errors = 0;

  vga_pattern_gen #(
    .COLOR_W(4), .CNT_W(CNT_W), .CLK_DIV(4),
    .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .NUM_BARS(7), .SCROLL_FRAMES(2)
  ) dut (
    .clock(clk), .reset(rst), .mode(mode),
    .hsync(hsync), .vsync(vsync),
    .red(red), .grn(grn), .blu(blu),
    .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int unsigned x;
    int unsigned y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] m, input int unsigned x, input int unsigned y,
                              input logic a, input logic hs, input logic vs,
                              input logic [11:0] rgb);
    vec_t v;
    v.mode = m; v.x = x; v.y = y; v.act = a; v.hs = hs; v.vs = vs; v.rgb = rgb;
    return v;
  endfunction

  function automatic logic [11:0] pal(input int unsigned i);
    case (i)
      0: return 12'h80F;
      1: return 12'h408;
      2: return 12'h00F;
      3: return 12'h0F0;
      4: return 12'hFF0;
      5: return 12'hF80;
      6: return 12'hF00;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (frame_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pixel(input int unsigned x, input int unsigned y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3300; i++) begin
      @(posedge clk); #1;
      if (pixel_x == 11'(x) && pixel_y == 11'(y)) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit          ok;
    bit          early;
    int          cnt;
    logic [1:0]  cur_mode;
    logic [11:0] exp_rgb;
    int unsigned r;

    // Modes 0, 1, 2 at hand-computed points, each mode group in raster order.
    tbl.push_back(mk(2'd0,  1,  1, 1, 1, 1, 12'h80F));
    tbl.push_back(mk(2'd0,  0,  5, 1, 1, 1, 12'h80F));
    tbl.push_back(mk(2'd0,  1,  5, 1, 1, 1, 12'h80F));
    tbl.push_back(mk(2'd0,  2,  5, 1, 1, 1, 12'h408));
    tbl.push_back(mk(2'd0, 11,  5, 1, 1, 1, 12'hF80));
    tbl.push_back(mk(2'd0, 12,  5, 1, 1, 1, 12'hF00));
    tbl.push_back(mk(2'd0, 15,  5, 1, 1, 1, 12'hF00));
    tbl.push_back(mk(2'd0, 16,  5, 0, 1, 1, 12'h000));
    tbl.push_back(mk(2'd0, 17,  5, 0, 0, 1, 12'h000));
    tbl.push_back(mk(2'd0, 18,  5, 0, 0, 1, 12'h000));
    tbl.push_back(mk(2'd0, 19,  5, 0, 1, 1, 12'h000));
    tbl.push_back(mk(2'd0,  3, 16, 0, 1, 1, 12'h000));
    tbl.push_back(mk(2'd0,  3, 17, 0, 1, 0, 12'h000));
    tbl.push_back(mk(2'd1,  9,  0, 1, 1, 1, 12'h80F));
    tbl.push_back(mk(2'd1,  3,  4, 1, 1, 1, 12'h00F));
    tbl.push_back(mk(2'd1,  0, 11, 1, 1, 1, 12'hF80));
    tbl.push_back(mk(2'd1, 15, 12, 1, 1, 1, 12'hF00));
    tbl.push_back(mk(2'd1,  5, 15, 1, 1, 1, 12'hF00));
    tbl.push_back(mk(2'd2,  2,  2, 1, 1, 1, 12'h00F));
    tbl.push_back(mk(2'd2,  4,  6, 1, 1, 1, 12'hF80));
    tbl.push_back(mk(2'd2,  9,  7, 1, 1, 1, 12'h80F));
    tbl.push_back(mk(2'd2, 13, 11, 1, 1, 1, 12'hFF0));
    tbl.push_back(mk(2'd2, 12, 15, 1, 1, 1, 12'hF80));

    mode = 2'd0;
    rst  = 1'b1;

    // Reset state.
    #20;
    check("rst_sync",   32'({hsync, vsync}), 32'h3);
    check("rst_rgb",    32'({red, grn, blu}), 32'h0);
    check("rst_flags",  32'({active, frame_start}), 32'h0);
    check("rst_pixel",  32'({pixel_x, pixel_y}), 32'h0);

    // Release on a falling edge; frame_start must arrive on the 4th rising edge.
    #30 rst = 1'b0;
    early = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (frame_start) early = 1'b1;
    end
    @(posedge clk); #1;
    check("fs_before_4th", 32'(early), 32'h0);
    check("fs_on_4th",     32'(frame_start), 32'h1);
    check("first_pixel",   32'({active, pixel_x, pixel_y}), {21'd0, 1'b1, 22'd0});
    check("first_rgb",     32'({red, grn, blu}), BORDER ? 32'hFFF : 32'h80F);

    // frame_start is one clock wide; then measure the frame period.
    @(posedge clk); #1;
    check("fs_width", 32'(frame_start), 32'h0);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (frame_start) break;
    end
    check("frame_period", 32'(cnt), 32'd1600);

    // Line period.
    wait_pixel(5, 2, ok);
    check("find_5_2", 32'(ok), 32'h1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (pixel_x == 11'd5 && pixel_y == 11'd3) break;
    end
    check("line_period", 32'(cnt), 32'd80);

    // hsync pulse: starts at x=17 and lasts 2 ticks (8 clocks).
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!hsync) begin ok = 1'b1; break; end
    end
    check("hsync_seen", 32'(ok), 32'h1);
    check("hsync_start_x", 32'(pixel_x), 32'd17);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (hsync) break;
      cnt++;
    end
    check("hsync_width", 32'(cnt), 32'd8);

    // vsync pulse: starts at line 17, x=0, lasts 2 lines (160 clocks).
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (!vsync) begin ok = 1'b1; break; end
    end
    check("vsync_seen", 32'(ok), 32'h1);
    check("vsync_start", 32'({pixel_x, pixel_y}), 32'({11'd0, 11'd17}));
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (vsync) break;
      cnt++;
    end
    check("vsync_width", 32'(cnt), 32'd160);

    // Table-driven pattern vectors.
    cur_mode = 2'd0;
    foreach (tbl[i]) begin
      if (tbl[i].mode != cur_mode) begin
        mode     = tbl[i].mode;
        cur_mode = tbl[i].mode;
        wait_frame_start(ok);
        check($sformatf("vec%0d_frame", i), 32'(ok), 32'h1);
      end
      wait_pixel(tbl[i].x, tbl[i].y, ok);
      check($sformatf("vec%0d_found", i), 32'(ok), 32'h1);
      exp_rgb = tbl[i].rgb;
      if (BORDER && tbl[i].act &&
          (tbl[i].x == 0 || tbl[i].x == 15 || tbl[i].y == 0 || tbl[i].y == 15))
        exp_rgb = 12'hFFF;
      check($sformatf("vec%0d_m%0d_(%0d,%0d)", i, tbl[i].mode, tbl[i].x, tbl[i].y),
            32'({active, hsync, vsync, red, grn, blu}),
            32'({tbl[i].act, tbl[i].hs, tbl[i].vs, exp_rgb}));
    end

    // Mid-frame mode change takes effect only at the next frame.
    mode = 2'd0;
    wait_frame_start(ok);
    check("mid_frame0", 32'(ok), 32'h1);
    wait_pixel(0, 3, ok);
    mode = 2'd1;
    wait_pixel(12, 5, ok);
    check("mid_found_a", 32'(ok), 32'h1);
    check("mid_old_mode", 32'({red, grn, blu}), 32'hF00);
    wait_frame_start(ok);
    check("mid_frame1", 32'(ok), 32'h1);
    wait_pixel(12, 5, ok);
    check("mid_found_b", 32'(ok), 32'h1);
    check("mid_new_mode", 32'({red, grn, blu}), 32'h00F);

    // Asynchronous reset mid-frame clears outputs immediately.
    wait_pixel(6, 5, ok);
    #2 rst = 1'b1;
    #1;
    check("midrst_sync",  32'({hsync, vsync}), 32'h3);
    check("midrst_out",   32'({active, frame_start, red, grn, blu}), 32'h0);
    check("midrst_pixel", 32'({pixel_x, pixel_y}), 32'h0);
    mode = 2'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Mode 3: rotation steps every 2 frames and wraps after 14 frames.
    for (int k = 0; k < 16; k++) begin
      r = (k / 2) % 7;
      wait_frame_start(ok);
      check($sformatf("rot_f%0d_frame", k), 32'(ok), 32'h1);
      wait_pixel(1, 5, ok);
      check($sformatf("rot_f%0d_x1", k), 32'({ok, red, grn, blu}), 32'({1'b1, pal(r)}));
      wait_pixel(12, 5, ok);
      check($sformatf("rot_f%0d_x12", k), 32'({ok, red, grn, blu}),
            32'({1'b1, pal((r + 6) % 7)}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
